// File: rtl/controle_rega.sv
// controle_rega -- irrigation controller FSM.
//
// Debounces the soil-dry, high-temperature and tank-low sensors. It then
// chooses sprinkler (ASPERSAO) or drip (GOTEJAMENTO) watering, limits the
// watering time, enforces a rest period (PAUSA) and raises an alarm (ALARME).
// All outputs are registered. They are decoded from the next state, so they
// change on the same edge as the state register.
//
// Optional feature (macro ALARM_LATCH_EN):
//   defined   -> leaving ALARME also needs an ack_alarme pulse. The pulse only
//                counts on a cycle where every other exit condition holds.
//   undefined -> ack_alarme is ignored and ALARME exits on its own.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   solo_seco, temp_alta,   raw asynchronous sensor inputs
//   nivel_baixo
//   ack_alarme              alarm acknowledge pulse (ALARM_LATCH_EN only)
//   AS / GT                 sprinkler / drip valve on
//   US                      soil satisfactory, system resting
//   alarm_wire              alarm active
//   estado                  current state code (debug)

// Synchronize and debounce one raw sensor bit.
// The filtered value flips only after the synchronized value has disagreed
// with it for DEB_CYCLES consecutive cycles.
module controle_rega_filtro #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);
  localparam int RUN_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEB_CYCLES - 1);

  logic             s1, s2;
  logic [RUN_W-1:0] run;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      filt <= 1'b0;
      run  <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 != filt) begin
        if (run == RUN_LAST) begin
          filt <= s2;
          run  <= '0;
        end else begin
          run <= run + 1'b1;
        end
      end else begin
        // One agreeing cycle restarts the run.
        run <= '0;
      end
    end
  end
endmodule

module controle_rega #(
  parameter int DEB_CYCLES = 4,
  parameter int T_MAX_REGA = 1000,
  parameter int T_PAUSA    = 200,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       solo_seco,
  input  logic       temp_alta,
  input  logic       nivel_baixo,
  input  logic       ack_alarme,
  output logic       AS,
  output logic       GT,
  output logic       US,
  output logic       alarm_wire,
  output logic [2:0] estado
);
  localparam int NUM_SENS = 3;
  localparam logic [CNT_W-1:0] CNT_REGA_LAST  = CNT_W'(T_MAX_REGA - 1);
  localparam logic [CNT_W-1:0] CNT_PAUSA_LAST = CNT_W'(T_PAUSA - 1);

  typedef enum logic [2:0] {
    OCIOSO      = 3'd0,
    ASPERSAO    = 3'd1,
    GOTEJAMENTO = 3'd2,
    PAUSA       = 3'd3,
    ALARME      = 3'd4
  } estado_t;

  // Sensor bit order: [0] soil dry, [1] temperature high, [2] tank low.
  logic [NUM_SENS-1:0] sens_raw, sens_f;
  assign sens_raw = {nivel_baixo, temp_alta, solo_seco};

  for (genvar i = 0; i < NUM_SENS; i++) begin : g_filt
    controle_rega_filtro #(.DEB_CYCLES(DEB_CYCLES)) u_filt (
      .clk  (clk),
      .reset(reset),
      .raw  (sens_raw[i]),
      .filt (sens_f[i])
    );
  end

  logic seco_f, temp_f, nivel_f;
  assign seco_f  = sens_f[0];
  assign temp_f  = sens_f[1];
  assign nivel_f = sens_f[2];

  estado_t          st, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ilegal, sai_alarme;

`ifdef ALARM_LATCH_EN
  assign sai_alarme = (cnt == CNT_PAUSA_LAST) && !nivel_f && ack_alarme;
`else
  assign sai_alarme = (cnt == CNT_PAUSA_LAST) && !nivel_f;
  logic unused_ack;
  assign unused_ack = ack_alarme;
`endif

  // cnt_nxt defaults to 0, so every state change clears the counter.
  always_comb begin
    nxt     = st;
    cnt_nxt = '0;
    ilegal  = 1'b0;
    case (st)
      OCIOSO: begin
        if (nivel_f)               nxt = ALARME;
        else if (seco_f && temp_f) nxt = ASPERSAO;
        else if (seco_f)           nxt = GOTEJAMENTO;
      end
      ASPERSAO, GOTEJAMENTO: begin
        // The watering mode is fixed at entry; temp_f is not consulted here.
        if (nivel_f)                   nxt = ALARME;
        else if (cnt == CNT_REGA_LAST) nxt = ALARME;
        else if (!seco_f)              nxt = PAUSA;
        else                           cnt_nxt = cnt + 1'b1;
      end
      PAUSA: begin
        if (nivel_f)                    nxt = ALARME;
        else if (cnt == CNT_PAUSA_LAST) nxt = OCIOSO;
        else                            cnt_nxt = cnt + 1'b1;
      end
      ALARME: begin
        if (sai_alarme)                 nxt = PAUSA;
        else if (cnt == CNT_PAUSA_LAST) cnt_nxt = cnt;  // saturate
        else                            cnt_nxt = cnt + 1'b1;
      end
      default: begin
        nxt    = OCIOSO;
        ilegal = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= OCIOSO;
      cnt        <= '0;
      AS         <= 1'b0;
      GT         <= 1'b0;
      US         <= 1'b0;
      alarm_wire <= 1'b0;
    end else begin
      st         <= nxt;
      cnt        <= cnt_nxt;
      AS         <= !ilegal && (nxt == ASPERSAO);
      GT         <= !ilegal && (nxt == GOTEJAMENTO);
      alarm_wire <= !ilegal && (nxt == ALARME);
      US         <= !ilegal && ((nxt == OCIOSO) || (nxt == PAUSA)) && !seco_f;
    end
  end

  assign estado = st;
endmodule

// File: tb/tb_controle_rega.sv
module tb_controle_rega;
  logic       clk = 1'b0;
  logic       reset, solo_seco, temp_alta, nivel_baixo, ack_alarme;
  logic       AS, GT, US, alarm_wire;
  logic [2:0] estado;

  controle_rega #(.DEB_CYCLES(4), .T_MAX_REGA(20), .T_PAUSA(8), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .solo_seco  (solo_seco),
    .temp_alta  (temp_alta),
    .nivel_baixo(nivel_baixo),
    .ack_alarme (ack_alarme),
    .AS         (AS),
    .GT         (GT),
    .US         (US),
    .alarm_wire (alarm_wire),
    .estado     (estado)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int         cyc;
    string      tag;
    logic [6:0] exp;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Expected vector layout: {alarm_wire, US, GT, AS, estado}
  function automatic logic [6:0] ev(input logic [2:0] st, input logic as_e,
                                    input logic gt_e, input logic us_e, input logic al_e);
    return {al_e, us_e, gt_e, as_e, st};
  endfunction

  task automatic push(input int c, input string tag, input logic [6:0] e);
    exp_t x;
    x.cyc = c; x.tag = tag; x.exp = e;
    sb.push_back(x);
  endtask

  task automatic go_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        chk(sb[i].tag, {25'd0, alarm_wire, US, GT, AS, estado}, {25'd0, sb[i].exp});
        sb.delete(i);
      end
    end
  end

  localparam logic [6:0] IDLE_US = 7'b0100000;  // OCIOSO, US=1
  localparam logic [6:0] GT_ON   = 7'b0010010;  // GOTEJAMENTO, GT=1
  localparam logic [6:0] ALARM   = 7'b1000100;  // ALARME, alarm=1

  int k, m, g, x, n, d, y, t, r, c, guard;

  initial begin
    reset = 1'b1; solo_seco = 1'b0; temp_alta = 1'b0; nivel_baixo = 1'b0; ack_alarme = 1'b0;

    // 1: reset held 3 cycles, then US rises one cycle after release
    go_to(3);
    k = cyc;
    push(k, "reset_state", 7'd0);
    reset = 1'b0;
    push(k + 1, "us_after_reset", IDLE_US);

    // 2: dry + hot -> sprinkler after 7 cycles; dry drops -> PAUSA 8 cycles -> OCIOSO
    go_to(k + 3);
    k = cyc;
    solo_seco = 1'b1; temp_alta = 1'b1;
    for (int j = 1; j <= 6; j++) push(k + j, "s2_debounce", IDLE_US);
    push(k + 7, "s2_as_on", ev(3'd1, 1, 0, 0, 0));
    push(k + 10, "s2_as_hold", ev(3'd1, 1, 0, 0, 0));
    go_to(k + 10);
    m = cyc;
    solo_seco = 1'b0; temp_alta = 1'b0;
    push(m + 6, "s2_as_before_pause", ev(3'd1, 1, 0, 0, 0));
    push(m + 7, "s2_pausa_first", ev(3'd3, 0, 0, 1, 0));
    push(m + 14, "s2_pausa_last", ev(3'd3, 0, 0, 1, 0));
    push(m + 15, "s2_back_idle", IDLE_US);

    // 4: two 3-cycle glitches on solo_seco never get through the filter
    go_to(m + 16);
    g = cyc;
    for (int j = 1; j <= 16; j++) push(g + j, "s4_glitch", IDLE_US);
    solo_seco = 1'b1;
    go_to(g + 3); solo_seco = 1'b0;
    go_to(g + 6); solo_seco = 1'b1;
    go_to(g + 9); solo_seco = 1'b0;

    // 3: dry only -> drip for 20 cycles, timeout alarm, 8 cycles later PAUSA
    go_to(g + 17);
    k = cyc;
    solo_seco = 1'b1;
    for (int j = 1; j <= 6; j++) push(k + j, "s3_debounce", IDLE_US);
    for (int j = 7; j <= 26; j++) push(k + j, "s3_gt_on", GT_ON);
    push(k + 27, "s3_timeout_alarm", ALARM);
    push(k + 34, "s3_alarm_hold", ALARM);
`ifdef ALARM_LATCH_EN
    push(k + 35, "s3_await_ack", ALARM);
    push(k + 36, "s3_await_ack2", ALARM);
    x = k + 37;
`else
    x = k + 35;
`endif
    push(x, "s3_pausa", ev(3'd3, 0, 0, 0, 0));
    push(x + 7, "s3_pausa_last", ev(3'd3, 0, 0, 0, 0));
    push(x + 8, "s3_idle_dry", ev(3'd0, 0, 0, 0, 0));
    push(x + 9, "s3_rewater", GT_ON);
`ifdef ALARM_LATCH_EN
    go_to(k + 30); ack_alarme = 1'b1;  // early ack, must be ignored
    go_to(k + 31); ack_alarme = 1'b0;
    go_to(k + 36); ack_alarme = 1'b1;
    go_to(k + 37); ack_alarme = 1'b0;
`endif

    // 5: tank low during drip -> alarm; tank recovers after 20 cycles
    go_to(x + 10);
    n = cyc;
    nivel_baixo = 1'b1;
    push(n + 6, "s5_gt_before_low", GT_ON);
    push(n + 7, "s5_low_alarm", ALARM);
    go_to(n + 20);
    d = cyc;
    nivel_baixo = 1'b0;
    push(d + 6, "s5_alarm_hold", ALARM);
`ifdef ALARM_LATCH_EN
    push(d + 7, "s5_await_ack", ALARM);
    y = d + 8;
`else
    y = d + 7;
`endif
    push(y, "s5_exit_pausa", ev(3'd3, 0, 0, 0, 0));
    push(y + 8, "s5_idle_dry", ev(3'd0, 0, 0, 0, 0));
    push(y + 9, "s5_rewater", GT_ON);
`ifdef ALARM_LATCH_EN
    go_to(d + 2); ack_alarme = 1'b1;  // tank still low, ack ignored
    go_to(d + 3); ack_alarme = 1'b0;
    go_to(d + 7); ack_alarme = 1'b1;
    go_to(d + 8); ack_alarme = 1'b0;
`endif

    // 6: temp_alta toggles during drip -> mode unchanged; reset closes the valve
    go_to(y + 10);
    t = cyc;
    for (int j = 0; j <= 15; j++) push(t + j, "s6_gt_temp_toggle", GT_ON);
    temp_alta = 1'b1;
    go_to(t + 9); temp_alta = 1'b0;
    go_to(t + 15);
    r = cyc;
    reset = 1'b1;
    push(r + 1, "s6_reset_closes", 7'd0);
    go_to(r + 1);
    reset = 1'b0; solo_seco = 1'b0;
    push(r + 2, "s6_post_reset", IDLE_US);

    // Dry and tank-low together in OCIOSO: the alarm wins and no valve opens
    go_to(r + 3);
    c = cyc;
    solo_seco = 1'b1; nivel_baixo = 1'b1;
    for (int j = 1; j <= 6; j++) push(c + j, "s7_debounce", IDLE_US);
    for (int j = 7; j <= 10; j++) push(c + j, "s7_alarm_wins", ALARM);

    go_to(c + 12);
    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
